// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types, opcode constants and HALT decode
package cpu_pkg;

  localparam logic [5:0] OP_B    = 6'b000101;
  localparam int         IMM26_W = 26;
  localparam int         IMM19_W = 19;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // HALT is encoded as an unconditional branch to itself (B #0)
  function automatic logic is_halt(input logic [31:0] instr);
    return (instr[31:26] == OP_B) && (instr[25:0] == '0);
  endfunction

endpackage

// File: rtl/branch_target.sv
// rtl/branch_target.sv - PC-relative branch target from imm26 or imm19
module branch_target
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]  PC,
  input  logic [IMM26_W-1:0] instruction,
  input  logic               UncondBr,
  output logic [ADDR_W-1:0]  target
);

  logic [ADDR_W-1:0] offset;

  // Pick the immediate field, sign-extend to full width, then scale words to bytes
  always_comb begin
    offset = '0;
    if (UncondBr) begin
      offset = {{(ADDR_W-IMM26_W){instruction[25]}}, instruction[25:0]};
    end else begin
      offset = {{(ADDR_W-IMM19_W){instruction[23]}}, instruction[23:5]};
    end
    target = PC + (offset << 2);
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, next-address select, HALT detect and retire counter
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              BrTaken,
  input  logic              UncondBr,
  input  logic              stall,
  output logic [ADDR_W-1:0] PC,
  output logic              fetch_valid,
  output logic              halted,
  output logic [31:0]       retired
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] pc_next;
  logic              halt_hit;
  logic              advance;

  assign halt_hit = is_halt(instruction);
  // An instruction retires only when it is actually consumed in RUN and is not HALT
  assign advance  = (state == RUN) && !stall && !halt_hit;
  assign pc_next  = BrTaken ? br_target : (pc_q + ADDR_W'(4));
  assign PC       = pc_q;

  branch_target #(
    .ADDR_W (ADDR_W)
  ) u_branch_target (
    .PC          (pc_q),
    .instruction (instruction[IMM26_W-1:0]),
    .UncondBr    (UncondBr),
    .target      (br_target)
  );

  // State register; reset always returns to BOOT
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: BOOT lasts one cycle, HALT is absorbing, stalls hold RUN
  always_comb begin
    state_next = state;
    case (state)
      BOOT: state_next = RUN;
      RUN:  if (!stall && halt_hit) state_next = HALT;
      HALT: state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    fetch_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      RUN:  fetch_valid = !stall;
      HALT: halted      = 1'b1;
      default: ;
    endcase
  end

  // PC and retire counter move together, only on a consumed non-HALT instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      retired <= '0;
    end else if (advance) begin
      pc_q    <= pc_next;
      retired <= retired + 32'd1;
    end
  end

endmodule
